// File: rtl/puzzle_stream_master_if.sv
// Word-stream link between the puzzle host master and the solver top.
//   tx_valid / tx_data : master -> solver (solver valid_in / data_in)
//   rx_ready           : master -> solver (solver dma_ready)
//   rx_valid / rx_data : solver -> master (solver valid_out / data_out)
// Modports: master (host side), slave (solver side).
interface puzzle_stream_master_if #(
    parameter int unsigned DATA_W = 32
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              rx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output tx_valid,
        output tx_data,
        output rx_ready,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  rx_ready,
        output rx_valid,
        output rx_data
    );
endinterface

// File: rtl/puzzle_stream_master.sv
// Host-side end of the solver word stream. Buffers a 9x9 puzzle, streams it
// cell by cell to the solver, waits a short gap, then collects the 81-word
// solution into a result buffer that the host reads back combinationally.
// Ports:
//   clk, reset_L        clock, asynchronous active-low reset
//   start               begin a transaction (accepted in IDLE or DONE)
//   ld_we/ld_addr/ld_digit  puzzle buffer write port (IDLE/DONE only)
//   rd_addr/rd_digit    result buffer read port (rd_digit combinational)
//   strm                stream interface (master modport)
//   busy, done          status; err_code: 0 ok, 1 timeout, 2 short, 3 malformed
//   unsolved            number of received words whose stored digit is 0
// Optional macro SUDOKU_CLUE_CHECK_EN: compares received digits against the
// clues and adds output clue_mismatch.
module puzzle_stream_master #(
    parameter int unsigned CELLS   = 81,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic                          start,
    input  logic                          ld_we,
    input  logic [6:0]                    ld_addr,
    input  logic [3:0]                    ld_digit,
    input  logic [6:0]                    rd_addr,
    output logic [3:0]                    rd_digit,
    puzzle_stream_master_if.master        strm,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    err_code,
    output logic [6:0]                    unsolved
`ifdef SUDOKU_CLUE_CHECK_EN
    ,
    output logic                          clue_mismatch
`endif
);

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned GW = 4;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT_RX,
        S_RECV,
        S_DONE
    } state_t;

    state_t         state_q, state_n;
    logic [AW-1:0]  idx_q, idx_n, idx_inc;
    logic [AW-1:0]  ridx_q, ridx_n;
    logic [GW-1:0]  gap_q, gap_n;
    logic [TW-1:0]  timer_q, timer_n, timer_inc;
    logic           tx_valid_q, tx_valid_n;
    logic [DW-1:0]  tx_data_q, tx_data_n;
    logic           rx_ready_q, rx_ready_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic [1:0]     err_q, err_n;
    logic [6:0]     unsolved_q, unsolved_n;
    logic [3:0]     puzzle_q [CELLS];
    logic [3:0]     result_q [CELLS];
    logic           res_clr, res_we;
    logic           cap_bad;
    logic [3:0]     cap_digit;
    logic           ld_ok;
`ifdef SUDOKU_CLUE_CHECK_EN
    logic           mism_q, mism_n;
`endif

    assign idx_inc   = idx_q + AW'(1);
    assign timer_inc = timer_q + TW'(1);

    // Received word sanitising: anything but {28'd0, 0..9} is stored as 0.
    assign cap_bad   = (strm.rx_data[DW-1:4] != '0) || (strm.rx_data[3:0] > 4'd9);
    assign cap_digit = cap_bad ? 4'd0 : strm.rx_data[3:0];

    assign ld_ok = ld_we && (ld_addr < AW'(CELLS)) &&
                   ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state and registered-output logic.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        ridx_n     = ridx_q;
        gap_n      = gap_q;
        timer_n    = timer_q;
        tx_data_n  = '0;
        err_n      = err_q;
        unsolved_n = unsolved_q;
        res_clr    = 1'b0;
        res_we     = 1'b0;
`ifdef SUDOKU_CLUE_CHECK_EN
        mism_n     = mism_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n    = S_SEND;
                    idx_n      = '0;
                    ridx_n     = '0;
                    tx_data_n  = {28'd0, puzzle_q[0]};
                    err_n      = 2'd0;
                    unsolved_n = '0;
                    res_clr    = 1'b1;
`ifdef SUDOKU_CLUE_CHECK_EN
                    mism_n     = 1'b0;
`endif
                end
            end
            S_SEND: begin
                if (idx_q == AW'(CELLS - 1)) begin
                    state_n = S_GAP;
                    gap_n   = '0;
                end else begin
                    idx_n     = idx_inc;
                    tx_data_n = {28'd0, puzzle_q[idx_inc]};
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_n = S_WAIT_RX;
                    timer_n = '0;
                end else begin
                    gap_n = gap_q + GW'(1);
                end
            end
            S_WAIT_RX, S_RECV: begin
                if (strm.rx_valid) begin
                    res_we = 1'b1;
                    ridx_n = ridx_q + AW'(1);
                    if (cap_bad) begin
                        err_n = 2'd3;
                    end
                    if (cap_digit == 4'd0) begin
                        unsolved_n = unsolved_q + 7'd1;
                    end
`ifdef SUDOKU_CLUE_CHECK_EN
                    if ((cap_digit != 4'd0) && (puzzle_q[ridx_q] != 4'd0) &&
                        (cap_digit != puzzle_q[ridx_q])) begin
                        mism_n = 1'b1;
                    end
`endif
                    if (ridx_q == AW'(CELLS - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_RECV;
                    end
                end else if (state_q == S_RECV) begin
                    err_n   = 2'd2;
                    state_n = S_DONE;
                end else begin
                    timer_n = timer_inc;
                    if (timer_inc == TW'(TIMEOUT)) begin
                        err_n   = 2'd1;
                        state_n = S_DONE;
                    end
                end
`ifdef SUDOKU_CLUE_CHECK_EN
                // A clue conflict outranks a short stream at completion.
                if ((state_n == S_DONE) && mism_n) begin
                    err_n = 2'd3;
                end
`endif
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        tx_valid_n = (state_n == S_SEND);
        rx_ready_n = (state_n == S_WAIT_RX) || (state_n == S_RECV);
        busy_n     = (state_n == S_SEND) || (state_n == S_GAP) ||
                     (state_n == S_WAIT_RX) || (state_n == S_RECV);
        done_n     = (state_n == S_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ridx_q     <= '0;
            gap_q      <= '0;
            timer_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 2'd0;
            unsolved_q <= '0;
`ifdef SUDOKU_CLUE_CHECK_EN
            mism_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            ridx_q     <= ridx_n;
            gap_q      <= gap_n;
            timer_q    <= timer_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
            rx_ready_q <= rx_ready_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
            unsolved_q <= unsolved_n;
`ifdef SUDOKU_CLUE_CHECK_EN
            mism_q     <= mism_n;
`endif
        end
    end

    // Puzzle buffer: host writes only while idle; out-of-range digits become blanks.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < int'(CELLS); i++) begin
                puzzle_q[i] <= 4'd0;
            end
        end else if (ld_ok) begin
            puzzle_q[ld_addr] <= (ld_digit > 4'd9) ? 4'd0 : ld_digit;
        end
    end

    // Result buffer: cleared when a transaction starts, filled in stream order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < int'(CELLS); i++) begin
                result_q[i] <= 4'd0;
            end
        end else if (res_clr) begin
            for (int i = 0; i < int'(CELLS); i++) begin
                result_q[i] <= 4'd0;
            end
        end else if (res_we) begin
            result_q[ridx_q] <= cap_digit;
        end
    end

    assign rd_digit      = (rd_addr < AW'(CELLS)) ? result_q[rd_addr] : 4'd0;
    assign strm.tx_valid = tx_valid_q;
    assign strm.tx_data  = tx_data_q;
    assign strm.rx_ready = rx_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_code      = err_q;
    assign unsolved      = unsolved_q;
`ifdef SUDOKU_CLUE_CHECK_EN
    assign clue_mismatch = mism_q;
`endif

endmodule

// File: tb/tb_puzzle_stream_master.sv
// Directed bench for puzzle_stream_master: streams a known puzzle, plays the
// solver side with a solution / truncated / corrupted stream, and checks
// status, timing and the result buffer against hand-derived values.
module tb_puzzle_stream_master;

    localparam int CELLS   = 81;
    localparam int GAP_CYC = 4;
    localparam int TIMEOUT = 4096;

    logic       clk;
    logic       reset_L;
    logic       start;
    logic       ld_we;
    logic [6:0] ld_addr;
    logic [3:0] ld_digit;
    logic [6:0] rd_addr;
    logic [3:0] rd_digit;
    logic       busy;
    logic       done;
    logic [1:0] err_code;
    logic [6:0] unsolved;
`ifdef SUDOKU_CLUE_CHECK_EN
    logic       clue_mismatch;
`endif

    puzzle_stream_master_if strm_if ();

    puzzle_stream_master dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .start    (start),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_digit (ld_digit),
        .rd_addr  (rd_addr),
        .rd_digit (rd_digit),
        .strm     (strm_if.master),
        .busy     (busy),
        .done     (done),
        .err_code (err_code),
        .unsolved (unsolved)
`ifdef SUDOKU_CLUE_CHECK_EN
        ,
        .clue_mismatch (clue_mismatch)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] puz [CELLS];
    logic [3:0] sol [CELLS];

    string puz_s = "530070000600195000098000060800060003400803001700020006060000280000419005000080079";
    string sol_s = "534678912672195348198342567859761423426853791713924856961537284287419635345286179";

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rx_word(input int i, input int kind);
        logic [31:0] w;
        w = {28'd0, sol[i]};
        if (kind == 1 && i == 5) w = 32'h0000_000C;
        if (kind == 1 && i == 7) w = 32'h0000_0000;
        if (kind == 2 && i == 0) w = 32'h0000_0006;
        return w;
    endfunction

    task automatic read_chk(input string tag, input int addr, input logic [3:0] exp);
        rd_addr = 7'(addr);
        #1;
        check(tag, 32'(rd_digit), 32'(exp));
    endtask

    // Start a transaction and check the outgoing stream plus the gap timing.
    task automatic run_send(input bit poke_busy);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            check($sformatf("tx_valid[%0d]", i), 32'(strm_if.tx_valid), 32'd1);
            check($sformatf("tx_data[%0d]", i), strm_if.tx_data, {28'd0, puz[i]});
            if (poke_busy && i == 10) begin
                ld_we    = 1'b1;
                ld_addr  = 7'd0;
                ld_digit = 4'd9;
                start    = 1'b1;
            end else begin
                ld_we = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
        end
        for (int g = 0; g < GAP_CYC; g++) begin
            check("gap_tx_valid", 32'(strm_if.tx_valid), 32'd0);
            check("gap_rx_ready", 32'(strm_if.rx_ready), 32'd0);
            @(negedge clk);
        end
        check("rx_ready_lat", 32'(strm_if.rx_ready), 32'd1);
        check("busy_wait", 32'(busy), 32'd1);
    endtask

    task automatic send_words(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            strm_if.rx_valid = 1'b1;
            strm_if.rx_data  = rx_word(i, kind);
            @(negedge clk);
        end
        strm_if.rx_valid = 1'b0;
        strm_if.rx_data  = '0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < CELLS; i++) begin
            puz[i] = 4'(int'(puz_s[i]) - 48);
            sol[i] = 4'(int'(sol_s[i]) - 48);
        end
        reset_L          = 1'b0;
        start            = 1'b0;
        ld_we            = 1'b0;
        ld_addr          = '0;
        ld_digit         = '0;
        rd_addr          = '0;
        strm_if.rx_valid = 1'b0;
        strm_if.rx_data  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_tx_valid", 32'(strm_if.tx_valid), 32'd0);
        check("rst_tx_data", strm_if.tx_data, 32'd0);
        check("rst_rx_ready", 32'(strm_if.rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_unsolved", 32'(unsolved), 32'd0);
        read_chk("rst_rd0", 0, 4'd0);
        reset_L = 1'b1;
        @(negedge clk);

        // Load puzzle; cell 1 then overwritten with 15 which must store as 0
        for (int i = 0; i < CELLS; i++) begin
            ld_we    = 1'b1;
            ld_addr  = 7'(i);
            ld_digit = puz[i];
            @(negedge clk);
        end
        ld_addr  = 7'd1;
        ld_digit = 4'd15;
        @(negedge clk);
        ld_we = 1'b0;
        puz[1] = 4'd0;

        // Stream out with ignored ld_we/start mid-SEND, then full solution back
        run_send(1'b1);
        send_words(CELLS, 0);
        check("ok_done", 32'(done), 32'd1);
        check("ok_busy", 32'(busy), 32'd0);
        check("ok_rx_ready", 32'(strm_if.rx_ready), 32'd0);
        check("ok_err", 32'(err_code), 32'd0);
        check("ok_unsolved", 32'(unsolved), 32'd0);
`ifdef SUDOKU_CLUE_CHECK_EN
        check("ok_clue_mismatch", 32'(clue_mismatch), 32'd0);
`endif
        for (int i = 0; i < CELLS; i++) begin
            read_chk($sformatf("ok_rd[%0d]", i), i, sol[i]);
        end
        read_chk("rd_oob81", 81, 4'd0);
        read_chk("rd_oob127", 127, 4'd0);

        // rx_valid while DONE is ignored
        strm_if.rx_valid = 1'b1;
        strm_if.rx_data  = 32'd9;
        @(negedge clk);
        strm_if.rx_valid = 1'b0;
        strm_if.rx_data  = '0;
        read_chk("done_rx_ignored", 0, sol[0]);
        check("done_unsolved_held", 32'(unsolved), 32'd0);

        // Timeout: rx_ready held exactly TIMEOUT cycles
        run_send(1'b0);
        n = 0;
        while (strm_if.rx_ready && n < TIMEOUT + 100) begin
            n++;
            @(negedge clk);
        end
        check("to_ready_cycles", 32'(n), 32'(TIMEOUT));
        check("to_err", 32'(err_code), 32'd1);
        check("to_done", 32'(done), 32'd1);
        read_chk("to_rd0_cleared", 0, 4'd0);

        // Short stream: 40 words then rx_valid drops
        run_send(1'b0);
        send_words(40, 0);
        @(negedge clk);
        check("short_done", 32'(done), 32'd1);
        check("short_err", 32'(err_code), 32'd2);
        check("short_unsolved", 32'(unsolved), 32'd0);
        read_chk("short_rd39", 39, sol[39]);
        read_chk("short_rd40", 40, 4'd0);
        read_chk("short_rd80", 80, 4'd0);

        // Malformed word at 5, zero digit at 7
        run_send(1'b0);
        send_words(CELLS, 1);
        check("bad_done", 32'(done), 32'd1);
        check("bad_err", 32'(err_code), 32'd3);
        check("bad_unsolved", 32'(unsolved), 32'd2);
        read_chk("bad_rd5", 5, 4'd0);
        read_chk("bad_rd6", 6, sol[6]);
        read_chk("bad_rd7", 7, 4'd0);
`ifdef SUDOKU_CLUE_CHECK_EN
        check("bad_clue_mismatch", 32'(clue_mismatch), 32'd0);
        run_send(1'b0);
        send_words(CELLS, 2);
        check("clue_mismatch", 32'(clue_mismatch), 32'd1);
        check("clue_err", 32'(err_code), 32'd3);
`endif

        // Reset asserted mid-RECV
        run_send(1'b0);
        send_words(20, 0);
        reset_L = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(strm_if.tx_valid), 32'd0);
        check("mid_rst_rx_ready", 32'(strm_if.rx_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err_code), 32'd0);
        read_chk("mid_rst_rd0", 0, 4'd0);
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
